// File: rtl/hazard_unit.sv
// Hazard detection and operand-forwarding unit beside the MIPS32 decode stage.
// Define HAZARD_ID_FORWARD_EN to enable forwarding into the ID-stage branch comparator.
module hazard_unit (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] id_signal_forwarding,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [4:0] id_dest,
  input  logic       id_reg_write,
  input  logic       id_mem_read,
  input  logic       mem_stall,
  output logic       id_stall,
  output logic [1:0] id_fwd_rs_sel,
  output logic [1:0] id_fwd_rt_sel,
  output logic [1:0] ex_fwd_rs_sel,
  output logic [1:0] ex_fwd_rt_sel
);

  typedef struct packed {
    logic [4:0] dest;
    logic       regWrite;
    logic       memRead;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       wantRs;
    logic       wantRt;
  } exRecT;

  typedef struct packed {
    logic [4:0] dest;
    logic       regWrite;
    logic       memRead;
  } memRecT;

  typedef struct packed {
    logic [4:0] dest;
    logic       regWrite;
  } wbRecT;

  exRecT  exRec_q,  exRec_d;
  memRecT memRec_q;
  wbRecT  wbRec_q;

  logic wantRsId, needRsId, wantRsEx, needRsEx;
  logic wantRtId, needRtId, wantRtEx, needRtEx;
  logic exWrRs, exWrRt, memWrRs, memWrRt, wbWrRs, wbWrRt;
  logic exShWrMemRs, exShWrMemRt, exShWrWbRs, exShWrWbRt;
  logic hazard;

  assign {wantRsId, needRsId, wantRsEx, needRsEx,
          wantRtId, needRtId, wantRtEx, needRtEx} = id_signal_forwarding;

  // Register 0 is hardwired, so a write to it never creates a dependency.
  function automatic logic writesReg(input logic regWrite, input logic [4:0] dest,
                                     input logic [4:0] r);
    return regWrite && (dest == r) && (r != 5'd0);
  endfunction

  function automatic logic [1:0] fwdSel(input logic want, input logic memHit,
                                        input logic memLoad, input logic wbHit);
    logic [1:0] sel;
    sel = 2'b00;
    if (want) begin
      if (memHit && !memLoad) sel = 2'b01;
      else if (wbHit)         sel = 2'b10;
    end
    return sel;
  endfunction

  assign exWrRs  = writesReg(exRec_q.regWrite,  exRec_q.dest,  id_rs);
  assign exWrRt  = writesReg(exRec_q.regWrite,  exRec_q.dest,  id_rt);
  assign memWrRs = writesReg(memRec_q.regWrite, memRec_q.dest, id_rs);
  assign memWrRt = writesReg(memRec_q.regWrite, memRec_q.dest, id_rt);
  assign wbWrRs  = writesReg(wbRec_q.regWrite,  wbRec_q.dest,  id_rs);
  assign wbWrRt  = writesReg(wbRec_q.regWrite,  wbRec_q.dest,  id_rt);

  assign exShWrMemRs = writesReg(memRec_q.regWrite, memRec_q.dest, exRec_q.rs);
  assign exShWrMemRt = writesReg(memRec_q.regWrite, memRec_q.dest, exRec_q.rt);
  assign exShWrWbRs  = writesReg(wbRec_q.regWrite,  wbRec_q.dest,  exRec_q.rs);
  assign exShWrWbRt  = writesReg(wbRec_q.regWrite,  wbRec_q.dest,  exRec_q.rt);

`ifdef HAZARD_ID_FORWARD_EN
  // Only a load still in MEM blocks the branch; ALU results there are forwarded.
  assign hazard = (needRsId && (exWrRs || (memWrRs && memRec_q.memRead))) ||
                  (needRtId && (exWrRt || (memWrRt && memRec_q.memRead))) ||
                  (needRsEx && exWrRs && exRec_q.memRead) ||
                  (needRtEx && exWrRt && exRec_q.memRead);

  assign id_fwd_rs_sel = fwdSel(wantRsId, memWrRs, memRec_q.memRead, wbWrRs);
  assign id_fwd_rt_sel = fwdSel(wantRtId, memWrRt, memRec_q.memRead, wbWrRt);
`else
  logic unusedIdFwd;
  assign unusedIdFwd = ^{wantRsId, wantRtId, wbWrRs, wbWrRt};

  assign hazard = (needRsId && (exWrRs || memWrRs)) ||
                  (needRtId && (exWrRt || memWrRt)) ||
                  (needRsEx && exWrRs && exRec_q.memRead) ||
                  (needRtEx && exWrRt && exRec_q.memRead);

  assign id_fwd_rs_sel = 2'b00;
  assign id_fwd_rt_sel = 2'b00;
`endif

  assign id_stall = mem_stall || hazard;

  assign ex_fwd_rs_sel = fwdSel(exRec_q.wantRs, exShWrMemRs, memRec_q.memRead, exShWrWbRs);
  assign ex_fwd_rt_sel = fwdSel(exRec_q.wantRt, exShWrMemRt, memRec_q.memRead, exShWrWbRt);

  always_comb begin
    exRec_d = '0;
    if (!hazard) begin
      exRec_d.dest     = id_dest;
      exRec_d.regWrite = id_reg_write;
      exRec_d.memRead  = id_mem_read;
      exRec_d.rs       = id_rs;
      exRec_d.rt       = id_rt;
      exRec_d.wantRs   = wantRsEx;
      exRec_d.wantRt   = wantRtEx;
    end
  end

  // A busy data memory freezes every stage, so a pending hazard survives it intact.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      exRec_q  <= '0;
      memRec_q <= '0;
      wbRec_q  <= '0;
    end else if (!mem_stall) begin
      exRec_q  <= exRec_d;
      memRec_q <= '{dest: exRec_q.dest, regWrite: exRec_q.regWrite, memRead: exRec_q.memRead};
      wbRec_q  <= '{dest: memRec_q.dest, regWrite: memRec_q.regWrite};
    end
  end

endmodule
